// File: rtl/mac_pe_column_if.sv
// Sample/flag/result bundle between the conv engine buffers and one MAC PE column.
interface mac_pe_column_if #(
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned WEIGHT_WIDTH  = 16,
    parameter int unsigned TAPS          = 9,
    parameter int unsigned ACC_WIDTH     = 48,
    parameter int unsigned OUT_WIDTH     = 36,
    parameter int unsigned SHIFT_WIDTH   = 6
);
    logic                            clr;
    logic                            in_valid;
    logic                            acc_first;
    logic                            acc_last;
    logic [TAPS*FEATURE_WIDTH-1:0]   x_vec;
    logic [TAPS*WEIGHT_WIDTH-1:0]    w_vec;
    logic signed [ACC_WIDTH-1:0]     bias;
    logic [SHIFT_WIDTH-1:0]          shift;
    logic signed [OUT_WIDTH-1:0]     out;
    logic                            out_valid;
    logic                            sat;

    modport master (
        output clr, in_valid, acc_first, acc_last, x_vec, w_vec, bias, shift,
        input  out, out_valid, sat
    );

    modport slave (
        input  clr, in_valid, acc_first, acc_last, x_vec, w_vec, bias, shift,
        output out, out_valid, sat
    );
endinterface

// File: rtl/mac_pe_column.sv
// Column of TAPS cascaded multiply-accumulate taps with input skew, multi-pass
// accumulation, bias injection on the first pass and round/shift/saturate output.
module mac_pe_column #(
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned WEIGHT_WIDTH  = 16,
    parameter int unsigned TAPS          = 9,
    parameter int unsigned ACC_WIDTH     = 48,
    parameter int unsigned OUT_WIDTH     = 36,
    parameter int unsigned SHIFT_WIDTH   = 6
) (
    input  logic           DSP_clk,
    input  logic           rst_n,
    mac_pe_column_if.slave pe
);
    localparam int unsigned FW  = FEATURE_WIDTH;
    localparam int unsigned WW  = WEIGHT_WIDTH;
    localparam int unsigned PW  = FW + WW;
    localparam int unsigned EW  = ACC_WIDTH + 1;
    localparam int unsigned SBD = TAPS + 1;

    localparam logic signed [EW-1:0] OUT_MAX = EW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [EW-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [FW-1:0]        tap_x  [TAPS];
    logic signed [WW-1:0]        tap_w  [TAPS];
    logic                        tap_v  [TAPS];
    logic signed [PW-1:0]        mult_c [TAPS];
    logic signed [ACC_WIDTH-1:0] prod_q [TAPS];
    logic signed [ACC_WIDTH-1:0] casc_q [TAPS];

    // Tap k sees the sample k cycles late so the cascade meets its own product.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_direct
            assign tap_x[k] = pe.x_vec[0 +: FW];
            assign tap_w[k] = pe.w_vec[0 +: WW];
            assign tap_v[k] = pe.in_valid;
        end else begin : g_skew
            logic [FW-1:0] x_sr [k];
            logic [WW-1:0] w_sr [k];
            logic          v_sr [k];

            always_ff @(posedge DSP_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        x_sr[i] <= '0;
                        w_sr[i] <= '0;
                        v_sr[i] <= 1'b0;
                    end
                end else begin
                    x_sr[0] <= pe.x_vec[k*FW +: FW];
                    w_sr[0] <= pe.w_vec[k*WW +: WW];
                    v_sr[0] <= pe.in_valid & ~pe.clr;
                    for (int i = 1; i < k; i++) begin
                        x_sr[i] <= x_sr[i-1];
                        w_sr[i] <= w_sr[i-1];
                        v_sr[i] <= v_sr[i-1] & ~pe.clr;
                    end
                end
            end

            assign tap_x[k] = x_sr[k-1];
            assign tap_w[k] = w_sr[k-1];
            assign tap_v[k] = v_sr[k-1];
        end

        assign mult_c[k] = PW'(tap_x[k]) * PW'(tap_w[k]);
    end

    // Registered products and the cascade adder chain; bubbles contribute zero.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
                casc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= (tap_v[k] && !pe.clr) ? ACC_WIDTH'(mult_c[k]) : '0;
            end
            casc_q[0] <= prod_q[0];
            for (int k = 1; k < TAPS; k++) begin
                casc_q[k] <= casc_q[k-1] + prod_q[k];
            end
        end
    end

    logic                        sb_v     [SBD];
    logic                        sb_first [SBD];
    logic                        sb_last  [SBD];
    logic signed [ACC_WIDTH-1:0] sb_bias  [SBD];
    logic [SHIFT_WIDTH-1:0]      sb_shift [SBD];

    // Sideband flags/bias/shift ride alongside the column sum.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SBD; i++) begin
                sb_v[i]     <= 1'b0;
                sb_first[i] <= 1'b0;
                sb_last[i]  <= 1'b0;
                sb_bias[i]  <= '0;
                sb_shift[i] <= '0;
            end
        end else begin
            sb_v[0]     <= pe.in_valid & ~pe.clr;
            sb_first[0] <= pe.acc_first;
            sb_last[0]  <= pe.acc_last;
            sb_bias[0]  <= pe.bias;
            sb_shift[0] <= pe.shift;
            for (int i = 1; i < SBD; i++) begin
                sb_v[i]     <= sb_v[i-1] & ~pe.clr;
                sb_first[i] <= sb_first[i-1];
                sb_last[i]  <= sb_last[i-1];
                sb_bias[i]  <= sb_bias[i-1];
                sb_shift[i] <= sb_shift[i-1];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        acc_v_q;
    logic                        acc_last_q;
    logic [SHIFT_WIDTH-1:0]      acc_shift_q;

    // Multi-pass accumulator: first pass reloads from bias, bubbles hold.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_v_q     <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_shift_q <= '0;
        end else if (pe.clr) begin
            acc_q   <= '0;
            acc_v_q <= 1'b0;
        end else begin
            acc_v_q <= sb_v[SBD-1];
            if (sb_v[SBD-1]) begin
                acc_q       <= (sb_first[SBD-1] ? sb_bias[SBD-1] : acc_q) + casc_q[TAPS-1];
                acc_last_q  <= sb_last[SBD-1];
                acc_shift_q <= sb_shift[SBD-1];
            end
        end
    end

    logic signed [EW-1:0]        rnd_c;
    logic signed [EW-1:0]        rsum_c;
    logic signed [EW-1:0]        r_c;
    logic signed [OUT_WIDTH-1:0] res_c;
    logic                        sat_c;

    // Round half up, arithmetic shift, then clamp; one spare bit keeps the rounding add exact.
    always_comb begin
        rnd_c  = '0;
        rsum_c = '0;
        r_c    = '0;
        res_c  = '0;
        sat_c  = 1'b0;
        if (32'(acc_shift_q) < ACC_WIDTH) begin
            if (acc_shift_q != '0) begin
                rnd_c = EW'(1) << (acc_shift_q - SHIFT_WIDTH'(1));
            end
            rsum_c = EW'(acc_q) + rnd_c;
            r_c    = rsum_c >>> acc_shift_q;
        end
        res_c = r_c[OUT_WIDTH-1:0];
        if (r_c > OUT_MAX) begin
            res_c = OUT_MAX[OUT_WIDTH-1:0];
            sat_c = 1'b1;
        end else if (r_c < OUT_MIN) begin
            res_c = OUT_MIN[OUT_WIDTH-1:0];
            sat_c = 1'b1;
        end
    end

    // Result register: out holds, out_valid and sat strobe for one cycle.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.out       <= '0;
            pe.out_valid <= 1'b0;
            pe.sat       <= 1'b0;
        end else begin
            pe.out_valid <= 1'b0;
            pe.sat       <= 1'b0;
            if (acc_v_q && acc_last_q && !pe.clr) begin
                pe.out       <= res_c;
                pe.out_valid <= 1'b1;
                pe.sat       <= sat_c;
            end
        end
    end
endmodule

// File: tb/tb_mac_pe_column.sv
// Directed self-checking bench for mac_pe_column with hand-computed expectations.
module tb_mac_pe_column;
    localparam int unsigned FW   = 16;
    localparam int unsigned WW   = 16;
    localparam int unsigned TAPS = 9;
    localparam int unsigned ACC  = 48;
    localparam int unsigned OW   = 36;
    localparam int unsigned SW   = 6;
    localparam int          LAT  = TAPS + 3;

    localparam longint P35 = 64'sd34359738368;
    localparam longint P46 = 64'sd70368744177664;

    typedef logic [TAPS*FW-1:0] xv_t;
    typedef logic [TAPS*WW-1:0] wv_t;

    typedef struct {
        int     cyc;
        longint val;
        logic   sat;
    } res_t;

    logic DSP_clk = 1'b0;
    logic rst_n;
    int   cyc     = 0;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    res_t res_q[$];

    mac_pe_column_if #(
        .FEATURE_WIDTH(FW), .WEIGHT_WIDTH(WW), .TAPS(TAPS),
        .ACC_WIDTH(ACC), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
    ) pe ();

    mac_pe_column #(
        .FEATURE_WIDTH(FW), .WEIGHT_WIDTH(WW), .TAPS(TAPS),
        .ACC_WIDTH(ACC), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
    ) dut (
        .DSP_clk (DSP_clk),
        .rst_n   (rst_n),
        .pe      (pe)
    );

    always #5 DSP_clk = ~DSP_clk;

    always @(posedge DSP_clk) cyc <= cyc + 1;

    always @(negedge DSP_clk) begin
        if (rst_n === 1'b1 && pe.out_valid === 1'b1)
            res_q.push_back('{cyc: cyc, val: longint'(pe.out), sat: pe.sat});
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_res(input string tag, input int idx, input longint exp_val,
                              input logic exp_sat, input int exp_cyc);
        if (idx < res_q.size()) begin
            check_val({tag, "_val"}, res_q[idx].val, exp_val);
            check_val({tag, "_sat"}, longint'(res_q[idx].sat), longint'(exp_sat));
            check_val({tag, "_cyc"}, longint'(res_q[idx].cyc), longint'(exp_cyc));
        end else begin
            check_val({tag, "_missing"}, longint'(res_q.size()), longint'(idx + 1));
        end
    endtask

    task automatic step(input logic v, input logic f, input logic l, input xv_t xv,
                        input wv_t wv, input longint b, input int s, input logic c,
                        output int c_out);
        @(posedge DSP_clk);
        #1;
        pe.in_valid  = v;
        pe.acc_first = f;
        pe.acc_last  = l;
        pe.x_vec     = xv;
        pe.w_vec     = wv;
        pe.bias      = ACC'(b);
        pe.shift     = SW'(s);
        pe.clr       = c;
        c_out        = cyc;
    endtask

    task automatic idle(input int n);
        int d;
        repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, 0, 0, 1'b0, d);
    endtask

    function automatic xv_t x_uni(input int val);
        xv_t v;
        for (int k = 0; k < TAPS; k++) v[k*FW +: FW] = FW'(val);
        return v;
    endfunction

    function automatic wv_t w_uni(input int val);
        wv_t v;
        for (int k = 0; k < TAPS; k++) v[k*WW +: WW] = WW'(val);
        return v;
    endfunction

    // x_k = k+1 with w = {12,2,2,...}: column sum 100, sensitive to tap ordering.
    function automatic xv_t x_ramp();
        xv_t v;
        for (int k = 0; k < TAPS; k++) v[k*FW +: FW] = FW'(k + 1);
        return v;
    endfunction

    function automatic wv_t w_100();
        wv_t v;
        for (int k = 0; k < TAPS; k++) v[k*WW +: WW] = WW'((k == 0) ? 12 : 2);
        return v;
    endfunction

    initial begin
        int     c0, c1, c2, c3;
        int     cs[8];
        xv_t    x5;
        longint b4[6];
        int     s4[6];
        longint e4[6];
        logic   t4sat[6];

        rst_n        = 1'b0;
        pe.clr       = 1'b0;
        pe.in_valid  = 1'b0;
        pe.acc_first = 1'b0;
        pe.acc_last  = 1'b0;
        pe.x_vec     = '0;
        pe.w_vec     = '0;
        pe.bias      = '0;
        pe.shift     = '0;
        repeat (3) @(posedge DSP_clk);
        #1;
        check_val("rst_out", longint'(pe.out), 0);
        check_val("rst_valid", longint'(pe.out_valid), 0);
        check_val("rst_sat", longint'(pe.sat), 0);
        rst_n = 1'b1;

        // Single pass, then a new first immediately after a last.
        res_q.delete();
        step(1'b1, 1'b1, 1'b1, x_uni(2), w_uni(3), 10, 0, 1'b0, c1);
        step(1'b1, 1'b1, 1'b1, x_ramp(), w_100(), 0, 0, 1'b0, c2);
        idle(LAT + 4);
        check_val("t1_cnt", longint'(res_q.size()), 2);
        expect_res("t1_single", 0, 64, 1'b0, c1 + LAT);
        expect_res("t1_refirst", 1, 100, 1'b0, c2 + LAT);

        // Three back-to-back passes.
        res_q.delete();
        step(1'b1, 1'b1, 1'b0, x_ramp(), w_100(), -50, 5, 1'b0, c0);
        step(1'b1, 1'b0, 1'b0, x_ramp(), w_100(), 999, 5, 1'b0, c0);
        step(1'b1, 1'b0, 1'b1, x_ramp(), w_100(), 999, 2, 1'b0, c3);
        idle(LAT + 4);
        check_val("t2_cnt", longint'(res_q.size()), 1);
        expect_res("t2_multi", 0, 63, 1'b0, c3 + LAT);

        // Rounding and negative results.
        res_q.delete();
        x5 = '0;
        x5[FW-1:0] = FW'(5);
        step(1'b1, 1'b1, 1'b1, '0, w_uni(1), -7, 1, 1'b0, cs[0]);
        step(1'b1, 1'b1, 1'b1, x5, w_uni(1), 0, 1, 1'b0, cs[1]);
        step(1'b1, 1'b1, 1'b1, x_ramp(), w_100(), -37, 0, 1'b0, cs[2]);
        step(1'b1, 1'b1, 1'b1, x_ramp(), w_100(), -200, 3, 1'b0, cs[3]);
        step(1'b1, 1'b1, 1'b1, '0, w_uni(1), -6, 2, 1'b0, cs[4]);
        idle(LAT + 4);
        check_val("t3_cnt", longint'(res_q.size()), 5);
        expect_res("t3_neg7_s1", 0, -3, 1'b0, cs[0] + LAT);
        expect_res("t3_pos5_s1", 1, 3, 1'b0, cs[1] + LAT);
        expect_res("t3_s0", 2, 63, 1'b0, cs[2] + LAT);
        expect_res("t3_neg100_s3", 3, -12, 1'b0, cs[3] + LAT);
        expect_res("t3_neg6_s2", 4, -1, 1'b0, cs[4] + LAT);

        // Saturation and clamp boundaries.
        res_q.delete();
        b4    = '{P35 - 1, -P35, P35, -P35 - 1, 2 * P35 - 2, 2 * P35 - 1};
        s4    = '{0, 0, 0, 0, 1, 1};
        e4    = '{P35 - 1, -P35, P35 - 1, -P35, P35 - 1, P35 - 1};
        t4sat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1'b1, 1'b1, 1'b1, x_uni(32767), w_uni(32767), P46, 0, 1'b0, c1);
        step(1'b1, 1'b1, 1'b1, x_uni(-32767), w_uni(32767), -P46, 0, 1'b0, c2);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1, '0, '0, b4[i], s4[i], 1'b0, cs[i]);
        idle(LAT + 4);
        check_val("t4_cnt", longint'(res_q.size()), 8);
        expect_res("t4_pos_sat", 0, P35 - 1, 1'b1, c1 + LAT);
        expect_res("t4_neg_sat", 1, -P35, 1'b1, c2 + LAT);
        for (int i = 0; i < 6; i++)
            expect_res($sformatf("t4_edge%0d", i), i + 2, e4[i], t4sat[i], cs[i] + LAT);

        // Bubbles between passes match the gap-free run.
        res_q.delete();
        step(1'b1, 1'b1, 1'b0, x_ramp(), w_100(), -50, 7, 1'b0, c0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, x_ramp(), w_100(), 999, 7, 1'b0, c0);
        idle(2);
        step(1'b1, 1'b0, 1'b1, x_ramp(), w_100(), 999, 2, 1'b0, c3);
        idle(LAT + 4);
        check_val("t5_bub_cnt", longint'(res_q.size()), 1);
        expect_res("t5_bubbles", 0, 63, 1'b0, c3 + LAT);

        // Flush mid-accumulation, including a sample presented with clr.
        res_q.delete();
        step(1'b1, 1'b1, 1'b0, x_ramp(), w_100(), 1000, 0, 1'b0, c0);
        step(1'b1, 1'b0, 1'b0, x_ramp(), w_100(), 0, 0, 1'b0, c0);
        step(1'b1, 1'b0, 1'b1, x_ramp(), w_100(), 0, 0, 1'b0, c0);
        idle(1);
        step(1'b1, 1'b1, 1'b1, x_uni(2), w_uni(3), 10, 0, 1'b1, c0);
        idle(LAT + 4);
        check_val("t5_clr_cnt", longint'(res_q.size()), 0);
        check_val("t5_clr_hold", longint'(pe.out), 63);
        step(1'b1, 1'b0, 1'b1, x_uni(2), w_uni(3), 999, 0, 1'b0, c1);
        step(1'b1, 1'b1, 1'b1, x_uni(2), w_uni(3), 10, 0, 1'b0, c2);
        idle(LAT + 4);
        check_val("t5_post_cnt", longint'(res_q.size()), 2);
        expect_res("t5_acc_zeroed", 0, 54, 1'b0, c1 + LAT);
        expect_res("t5_clean", 1, 64, 1'b0, c2 + LAT);

        // Async reset while one result strobes and another is in flight.
        res_q.delete();
        step(1'b1, 1'b1, 1'b1, x_uni(2), w_uni(3), 10, 0, 1'b0, c1);
        step(1'b1, 1'b1, 1'b1, x_ramp(), w_100(), 0, 0, 1'b0, c0);
        idle(LAT - 1);
        check_val("t6_pre_valid", longint'(pe.out_valid), 1);
        check_val("t6_pre_out", longint'(pe.out), 64);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_out", longint'(pe.out), 0);
        check_val("t6_rst_valid", longint'(pe.out_valid), 0);
        check_val("t6_rst_sat", longint'(pe.sat), 0);
        repeat (2) @(posedge DSP_clk);
        #3;
        rst_n = 1'b1;
        res_q.delete();
        step(1'b1, 1'b0, 1'b1, x_ramp(), w_100(), 999, 0, 1'b0, c1);
        step(1'b1, 1'b0, 1'b1, x_ramp(), w_100(), 999, 0, 1'b0, c2);
        step(1'b1, 1'b1, 1'b1, x_ramp(), w_100(), 5, 0, 1'b0, c3);
        idle(LAT + 4);
        check_val("t6_post_cnt", longint'(res_q.size()), 3);
        expect_res("t6_acc_reset", 0, 100, 1'b0, c1 + LAT);
        expect_res("t6_continue", 1, 200, 1'b0, c2 + LAT);
        expect_res("t6_single", 2, 105, 1'b0, c3 + LAT);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stuck at cycle %0d, required end of stimulus", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mac_pe_column.md
Name: mac_pe_column

Overview:
- Parametrised successor to the single-tap cascaded MAC PE: a column of TAPS multiply-accumulate taps chained through an internal cascade bus.
- Adds multi-pass accumulation across input channels, bias injection on the first pass, and round/shift/saturate to the output width.
- Adds valid tracking and synchronous flush.
- Sits in the conv engine between the feature/weight buffers and the output writeback; one instance computes one output pixel's kernel window.

Parameters:
- FEATURE_WIDTH, 16, signed feature element width.
- WEIGHT_WIDTH, 16, signed weight element width.
- TAPS, 9, number of cascaded taps (1..32).
- ACC_WIDTH, 48, cascade/accumulator width; must be >= FEATURE_WIDTH+WEIGHT_WIDTH+clog2(TAPS).
- OUT_WIDTH, 36, signed output width after shift and saturate.
- SHIFT_WIDTH, 6, width of the shift control.

Ports:
- DSP_clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- clr, in, 1: synchronous flush of all valids and the accumulator.
- in_valid, in, 1: x_vec/w_vec/flags valid this cycle.
- acc_first, in, 1: sample starts a new accumulation (bias loaded); qualified by in_valid.
- acc_last, in, 1: sample ends the accumulation (result emitted); qualified by in_valid.
- x_vec, in, TAPS*FEATURE_WIDTH: features; tap k at bits [k*FW +: FW].
- w_vec, in, TAPS*WEIGHT_WIDTH: weights, same packing.
- bias, in, ACC_WIDTH: signed bias, sampled with acc_first.
- shift, in, SHIFT_WIDTH: arithmetic right shift, sampled with acc_last.
- out, out, OUT_WIDTH: signed result.
- out_valid, out, 1: one-cycle strobe, out valid.
- sat, out, 1: saturation occurred on this result; aligned with out_valid.

Behaviour:
- Reset (rst_n low, async): out=0, out_valid=0, sat=0, accumulator=0, all pipeline valids and skew registers cleared.
- Skew: tap k's x/w/valid are delayed k cycles internally, so the user presents all taps in one cycle. Tap k multiplies in cycle c+k+1 (registered product), then adds it to tap k-1's cascade output in cycle c+k+2.
- Tap 0 cascade input is 0. Products are sign-extended to ACC_WIDTH. Cascade adds and accumulator wrap modulo 2^ACC_WIDTH with no overflow detection.
- The column sum for a sample presented in cycle c is valid at cycle c+TAPS+1. Flags, bias and shift travel with it in a TAPS+1-deep sideband delay line.
- Accumulate stage (+1 cycle): acc_first loads acc = bias + sum, otherwise acc = acc + sum. Bubbles (in_valid=0) leave acc unchanged. Samples arrive back-to-back at one per cycle with no stall.
- Output stage (+1 cycle), only when acc_last:
  - With shift=s>0, compute r = (acc + 2^(s-1)) >>> s (round half up). With s=0, r = acc.
  - If r > 2^(OUT_WIDTH-1)-1 or r < -2^(OUT_WIDTH-1), clamp and set sat=1.
  - out_valid pulses for exactly one cycle.
  - out holds its value until the next result. sat is meaningful only with out_valid and is 0 otherwise.
- Latency: in_valid with acc_last in cycle c gives out_valid in cycle c+TAPS+3.
- acc_first and acc_last on the same sample: single-pass result = bias + sum.
- acc_last without a prior acc_first continues from the held acc (defined, not an error).
- A new acc_first in the cycle right after an acc_last sample is legal. The accumulate stage uses the loaded value, not the old acc.
- clr:
  - Drops every in-flight sample, zeroes acc and forces out_valid=0 from the next cycle. out keeps its last value.
  - clr with in_valid in the same cycle: clr wins and the sample is discarded.
- Mid-operation async reset discards all state. The first post-reset sample must carry acc_first to get a bias-correct result.

Test Plan:
- Single pass, TAPS=9, all x=2, w=3, bias=10, shift=0, first=last=1 -> out=64, sat=0, out_valid exactly at c+12.
- Three passes on back-to-back cycles, each pass sum=100, bias=-50, first on pass 1, last on pass 3, shift=2 -> out=(250+2)>>>2=63, one out_valid strobe only.
- Rounding and negatives: acc=-7, shift=1 -> out=-3; acc=5, shift=1 -> out=3; shift=0 -> out=acc.
- Saturation: x=w=32767 on all taps, bias=2^46, shift=0 -> out=2^35-1, sat=1. Negated case -> out=-2^35, sat=1.
- Bubbles and flush: insert in_valid=0 gaps between passes -> result equals the gap-free run. Assert clr mid-accumulation -> no out_valid for the discarded passes, and the next first/last sample gives a clean result.
- Async reset during a pass -> out=0, out_valid=0 immediately. Post-reset single-pass sample -> correct value at c+TAPS+3.
